gf2m_inverter_seq: RTL and testbench

- Iterative multiplicative inverter over GF(2^M) for the AES S-box datapath. Parametrised in field width and reduction polynomial.
- Computes a^(2^M-2) by repeated squaring and multiplying: one square plus one multiply per cycle.
- Sits between the byte-substitution input register and the affine-transform stage. Uses a valid/ready handshake on both sides.
- Replaces fixed-width combinational subfield inverters wherever area matters more than throughput.

---
 rtl/gf2m_inverter_seq.sv | 111 +++++++++++
 tb/tb_gf2m_inverter_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_inverter_seq.sv
// rtl/gf2m_inverter_seq.sv - sequential GF(2^M) inverter computing a^(2^M-2) by square-and-multiply
// Optional result self-check (chk_err port) enabled by GF2M_INV_SELFCHECK_EN.
module gf2m_inverter_seq #(
   parameter int         M     = 8,
   parameter logic [M:0] POLY  = 9'h11B,
   parameter int         CNT_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
`ifdef GF2M_INV_SELFCHECK_EN
   output logic         chk_err,
`endif
   output logic [M-1:0] out_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_n;
   logic [M-1:0]       sq, res;
   logic [M-1:0]       sq2, res_n;
   logic [CNT_W-1:0]   cnt;

   // Carry-less product of two field elements, reduced modulo POLY.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [2*M-2:0] p;
      p = '0;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ ((2*M-1)'(a) << i);
      end
      for (int i = 2*M-2; i >= M; i--) begin
         if (p[i]) p = p ^ ((2*M-1)'(POLY) << (i - M));
      end
      return p[M-1:0];
   endfunction

   assign sq2   = gf_mul(sq, sq);
   assign res_n = gf_mul(res, sq2);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (in_valid) state_n = RUN;
         RUN:  if (cnt == CNT_W'(M-2)) state_n = DONE;
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      case (state)
         IDLE: in_ready = ~rst;
         DONE: begin
            out_valid = 1'b1;
            out_data  = res;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sq    <= '0;
         res   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: if (in_valid) begin
               sq  <= in_data;
               res <= M'(1);
               cnt <= '0;
            end
            // After step j, res = a^(2+4+...+2^(j+1)); M-1 steps give a^(2^M-2).
            RUN: begin
               sq  <= sq2;
               res <= res_n;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef GF2M_INV_SELFCHECK_EN
   logic [M-1:0] a_saved;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_saved <= '0;
      end else if (state == IDLE && in_valid) begin
         a_saved <= in_data;
      end
   end

   // Purely combinational over the held DONE result, so it costs no cycles.
   always_comb begin
      chk_err = 1'b0;
      if (state == DONE && a_saved != '0 && gf_mul(a_saved, res) != M'(1)) chk_err = 1'b1;
   end
`endif

endmodule

// File: tb/tb_gf2m_inverter_seq.sv
// tb/tb_gf2m_inverter_seq.sv - randomized self-checking bench for gf2m_inverter_seq (M=8 and M=4 instances)
module tb_gf2m_inverter_seq;

   logic       clk;
   logic       rst;

   logic       in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0] in_data8, out_data8;
   logic       in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0] in_data4, out_data4;
`ifdef GF2M_INV_SELFCHECK_EN
   logic       chk_err8, chk_err4;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   gf2m_inverter_seq #(.M(8), .POLY(9'h11B), .CNT_W(4)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_data   (in_data8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
`ifdef GF2M_INV_SELFCHECK_EN
      .chk_err   (chk_err8),
`endif
      .out_data  (out_data8)
   );

   gf2m_inverter_seq #(.M(4), .POLY(5'h13), .CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
`ifdef GF2M_INV_SELFCHECK_EN
      .chk_err   (chk_err4),
`endif
      .out_data  (out_data4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Polynomial product over GF(2) followed by long division by poly.
   function automatic int ref_mul(input int a, input int b, input int m, input int poly);
      int p = 0;
      for (int i = 0; i < m; i++) if ((b >> i) & 1) p = p ^ (a << i);
      for (int i = 2*m-2; i >= m; i--) if ((p >> i) & 1) p = p ^ (poly << (i - m));
      return p;
   endfunction

   // Inverse found by exhaustive search for b with a*b = 1.
   function automatic int ref_inv(input int a, input int m, input int poly);
      if (a == 0) return 0;
      for (int b = 1; b < (1 << m); b++) if (ref_mul(a, b, m, poly) == 1) return b;
      return -1;
   endfunction

   task automatic txn8(input int a, input int stall);
      int cycles = 0;
      bit to = 1'b1;
      int exp = ref_inv(a, 8, 'h11B);
      @(negedge clk);
      check("acc_ready8", in_ready8, 1);
      in_valid8 = 1'b1;
      in_data8  = a[7:0];
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      in_data8 = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (out_valid8) begin
            to = 1'b0;
            break;
         end
         check("run_in_ready8", in_ready8, 0);
      end
      check("timeout8", 32'(to), 0);
      if (to) return;
      check("lat8", cycles, 7);
      check("data8", out_data8, exp);
`ifdef GF2M_INV_SELFCHECK_EN
      check("chk_err8", chk_err8, 0);
`endif
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid8", out_valid8, 1);
         check("hold_data8", out_data8, exp);
         check("hold_in_ready8", in_ready8, 0);
      end
      out_ready8 = 1'b1;
      @(posedge clk);
      #1 out_ready8 = 1'b0;
      @(negedge clk);
      check("drop_valid8", out_valid8, 0);
      check("idle_ready8", in_ready8, 1);
   endtask

   task automatic txn4(input int a);
      int cycles = 0;
      bit to = 1'b1;
      @(negedge clk);
      check("acc_ready4", in_ready4, 1);
      in_valid4 = 1'b1;
      in_data4  = a[3:0];
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      in_data4 = 4'($urandom);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (out_valid4) begin
            to = 1'b0;
            break;
         end
      end
      check("timeout4", 32'(to), 0);
      if (to) return;
      check("lat4", cycles, 3);
      check("data4", out_data4, ref_inv(a, 4, 'h13));
      if (a != 0) check("prod4", ref_mul(a, int'(out_data4), 4, 'h13), 1);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
   endtask

   initial begin
      int list[3];
      int t_prev;
      bit to;
      list = '{8'h01, 8'h02, 8'h00};
      rst = 1'b1;
      in_valid8 = 0; in_data8 = 0; out_ready8 = 0;
      in_valid4 = 0; in_data4 = 0; out_ready4 = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready8", in_ready8, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready8", in_ready8, 1);
      check("post_rst_out_valid8", out_valid8, 0);
      check("post_rst_out_data8", out_data8, 0);
      check("post_rst_in_ready4", in_ready4, 1);

      txn8('h53, 0);
      check("ref_53", ref_inv('h53, 8, 'h11B), 'hCA);
      txn8('h02, 5);

      // Streaming with in_valid held high and out_ready high.
      out_ready8 = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("b2b_ready", in_ready8, 1);
         in_valid8 = 1'b1;
         in_data8  = list[i][7:0];
         to = 1'b1;
         for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (i == 2) in_valid8 = 1'b0;
            if (out_valid8) begin
               to = 1'b0;
               break;
            end
         end
         check("b2b_timeout", 32'(to), 0);
         check("b2b_data", out_data8, ref_inv(list[i], 8, 'h11B));
         if (i > 0) check("b2b_spacing", cyc - t_prev, 9);
         t_prev = cyc;
      end
      in_valid8 = 1'b0;
      @(posedge clk);
      #1 out_ready8 = 1'b0;

      // Reset in the third RUN cycle discards the operation.
      @(negedge clk);
      in_valid8 = 1'b1;
      in_data8  = 8'h53;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid8, 0);
      check("midrst_in_ready", in_ready8, 1);
      txn8('h53, 0);

      for (int i = 0; i < 16; i++) txn8(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
`ifdef GF2M_INV_SELFCHECK_EN
      for (int i = 0; i < 256; i++) txn8(i, 0);
`endif
      for (int i = 0; i < 16; i++) txn4(i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
